window_3x3_gen: RTL and testbench
=================================

Name: window_3x3_gen

Overview:
Streaming 3x3 neighbourhood generator, the producer side of the 9-pixel window interface consumed by the edge-preserving and smoothing filter blocks (in1..in9, row-major, in5 = centre). Accepts one raster-order pixel per valid cycle and buffers two image lines. Emits a registered 3x3 window with a valid strobe for every interior centre pixel. Sits between the pixel source (dark-channel / transmission path) and the kernel blocks.

Parameters:
IMG_WIDTH, 512, pixels per line; ≥3.
IMG_HEIGHT, 512, lines per frame; ≥3.
DATA_W, 8, bits per pixel.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  pixel strobe; no backpressure, every valid pixel is accepted.
in_sof  in  1  qualified by in_valid; marks this pixel as (row 0, col 0).
in_pixel  in  DATA_W  raster-order pixel.
out_valid  out  1  window strobe, one cycle per window.
out_eof  out  1  high with the last window of a frame.
in1..in9  out  DATA_W each  window; in1 = (r-1,c-1), in2 = (r-1,c), in3 = (r-1,c+1), in4..in6 = row r, in7..in9 = row r+1.

Behaviour:
- Reset: out_valid=0, out_eof=0, in1..in9=0, row=col=0. Line-buffer RAM is not cleared; stale contents are never emitted.
- Pixel accepted at (row,col) when in_valid=1. Idle cycles with in_valid=0 change nothing; outputs hold and out_valid=0.
- Two line buffers, depth IMG_WIDTH, asynchronous read, read-before-write at the same address:
  - lb0[col] holds row-1.
  - lb1[col] holds row-2.
  - On accept: lb1[col]<=lb0[col], lb0[col]<=in_pixel.
- Column shift register of 3x3 regs. On accept, shift left and load the new right column = {lb1[col], lb0[col], in_pixel}, top to bottom.
- Window emitted when row≥2 and col≥2. Centre = (row-1, col-1). Outputs are registered: out_valid and in1..in9 update on the clock edge after the accepting edge (latency 1 cycle from acceptance of pixel (r+1,c+1)).
- Windows spanning a line wrap (col<2) are never emitted. Shift-register contents across the wrap are don't-care.
- Counters:
  - col increments per accept; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), row and col both wrap to 0.
  - out_eof asserts with the window whose centre is (IMG_HEIGHT-2, IMG_WIDTH-2).
- Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- in_sof with in_valid: the pixel is treated as (0,0) regardless of counter state. Counters become col=1,row=0 after the edge. Any partial frame is abandoned without out_eof. Redundant sof at a natural (0,0) has no effect.
- rst mid-frame: clears as above on that edge; the next accepted pixel is (0,0).
- Arithmetic: counters are $clog2(IMG_WIDTH) / $clog2(IMG_HEIGHT) bits, compared against parameter-1. No pixel arithmetic is performed; data passes through bit-exact.
- Back-to-back frames need no gap cycles.

Decomposition:
- Shared package: DATA_W default, window index constants (centre index 5), a localparam function for counter widths.
- One sub-module: line_buffer, a parameterised depth x DATA_W RAM with async read, sync write, and read-before-write. Instantiated twice.
- Counters, shift register and output stage stay in the top module.

Test Plan:
- IMG_WIDTH=IMG_HEIGHT=4, p(r,c)=10r+c, continuous valid from sof. The first out_valid is 1 cycle after p(2,2)=22 is accepted. Window = 0,1,2,10,11,12,20,21,22; out_eof=0.
- Same frame continuing: exactly 4 windows, with in9 = 22, 23, 32, 33. out_eof high only with in9=33. Next window for in9=33 is on the next clock after accept.
- Same image with in_valid toggling 1,0,0,1: identical window values and ordering. out_valid never high on a cycle not following an accept, and outputs hold during gaps.
- Two frames back-to-back, frame 2 = frame 1 + 100. Frame-2 first window = 100,101,102,110,...,122 with no frame-1 data leaking.
- Assert in_sof at frame-1 pixel (3,1), then send a full frame. No out_eof for frame 1, and frame 2 produces 4 correct windows.
- Assert rst during row 2. The cycle after, out_valid=0 and all outputs are 0. A fresh frame then yields the first window 0,1,2,10,11,12,20,21,22.

Source files
------------

// File: rtl/window_3x3_gen_pkg.sv
// Shared definitions for the 3x3 window generator: pixel width default,
// window tap indexing and the counter-width helper.
package window_3x3_gen_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int WIN_TAPS   = 9;
    localparam int WIN_CENTRE = 5;

    function automatic int cnt_width(input int n);
        if (n > 2) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One image line of storage: asynchronous read, synchronous write, so a read
// and write at the same address in one cycle returns the previous contents.
module line_buffer
    import window_3x3_gen_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    assign rd_data = mem_r[addr];

    // Line storage write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: buffers two lines and emits a
// registered window for every interior centre pixel of a raster frame.
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    output logic              out_eof,
    output logic [DATA_W-1:0] in1,
    output logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] in3,
    output logic [DATA_W-1:0] in4,
    output logic [DATA_W-1:0] in5,
    output logic [DATA_W-1:0] in6,
    output logic [DATA_W-1:0] in7,
    output logic [DATA_W-1:0] in8,
    output logic [DATA_W-1:0] in9
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(2);
    localparam logic [RW-1:0] ROW_WIN  = RW'(2);

    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [CW-1:0]     cur_col_s;
    logic [RW-1:0]     cur_row_s;
    logic              accept_s;
    logic              emit_s;
    logic              last_s;
    logic [DATA_W-1:0] lb0_rd_s;
    logic [DATA_W-1:0] lb1_rd_s;
    logic [DATA_W-1:0] new_col_s [3];
    logic [DATA_W-1:0] sh_r      [3][2];
    logic [DATA_W-1:0] win_s     [WIN_TAPS];
    logic [DATA_W-1:0] out_win_r [WIN_TAPS];
    logic              out_valid_r;
    logic              out_eof_r;

    assign accept_s = in_valid;

    // Position of the incoming pixel; start-of-frame forces (0,0).
    always_comb begin
        cur_col_s = col_r;
        cur_row_s = row_r;
        if (in_sof) begin
            cur_col_s = {CW{1'b0}};
            cur_row_s = {RW{1'b0}};
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
    end

    assign emit_s = accept_s && (cur_row_s >= ROW_WIN) && (cur_col_s >= COL_WIN);
    assign last_s = (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);

    line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .AW(CW)) u_lb0 (
        .clk     (clk),
        .wr_en   (accept_s),
        .addr    (cur_col_s),
        .wr_data (in_pixel),
        .rd_data (lb0_rd_s)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept_s),
        .addr    (cur_col_s),
        .wr_data (lb0_rd_s),
        .rd_data (lb1_rd_s)
    );

    // The rightmost window column comes straight from the buffers and input,
    // so only the two older columns need to be held in registers.
    always_comb begin
        new_col_s[0] = lb1_rd_s;
        new_col_s[1] = lb0_rd_s;
        new_col_s[2] = in_pixel;
        for (int i = 0; i < 3; i++) begin
            win_s[3*i]     = sh_r[i][0];
            win_s[3*i + 1] = sh_r[i][1];
            win_s[3*i + 2] = new_col_s[i];
        end
    end

    // Raster position counters with line and frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (accept_s) begin
            if (cur_col_s == COL_LAST) begin
                col_r <= {CW{1'b0}};
                if (cur_row_s == ROW_LAST) begin
                    row_r <= {RW{1'b0}};
                end else begin
                    row_r <= cur_row_s + RW'(1);
                end
            end else begin
                col_r <= cur_col_s + CW'(1);
                row_r <= cur_row_s;
            end
        end
    end

    // Column shift register of the two previous window columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                sh_r[i][0] <= {DATA_W{1'b0}};
                sh_r[i][1] <= {DATA_W{1'b0}};
            end
        end else if (accept_s) begin
            for (int i = 0; i < 3; i++) begin
                sh_r[i][0] <= sh_r[i][1];
                sh_r[i][1] <= new_col_s[i];
            end
        end
    end

    // Registered window output; values hold between emitted windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_eof_r   <= 1'b0;
            for (int k = 0; k < WIN_TAPS; k++) begin
                out_win_r[k] <= {DATA_W{1'b0}};
            end
        end else begin
            out_valid_r <= emit_s;
            out_eof_r   <= emit_s && last_s;
            if (emit_s) begin
                out_win_r <= win_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_eof   = out_eof_r;
    assign in1 = out_win_r[0];
    assign in2 = out_win_r[1];
    assign in3 = out_win_r[2];
    assign in4 = out_win_r[3];
    assign in5 = out_win_r[WIN_CENTRE - 1];
    assign in6 = out_win_r[5];
    assign in7 = out_win_r[6];
    assign in8 = out_win_r[7];
    assign in9 = out_win_r[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomised self-checking bench for window_3x3_gen on a 4x4 image, compared
// against a frame-array reference model of the neighbourhood rules.
module tb_window_3x3_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_pixel = 8'd0;
    logic          out_valid;
    logic          out_eof;
    logic [DW-1:0] in1, in2, in3, in4, in5, in6, in7, in8, in9;
    logic [DW-1:0] dut_win [9];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int img [H][W];
    int m_row = 0;
    int m_col = 0;
    int exp_win [9];
    logic exp_valid;
    logic exp_eof;
    int dut_win_cnt = 0;
    int dut_eof_cnt = 0;

    window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_pixel(in_pixel), .out_valid(out_valid), .out_eof(out_eof),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
        .in6(in6), .in7(in7), .in8(in8), .in9(in9)
    );

    assign dut_win[0] = in1; assign dut_win[1] = in2; assign dut_win[2] = in3;
    assign dut_win[3] = in4; assign dut_win[4] = in5; assign dut_win[5] = in6;
    assign dut_win[6] = in7; assign dut_win[7] = in8; assign dut_win[8] = in9;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_row = 0;
        m_col = 0;
        for (int k = 0; k < 9; k++) exp_win[k] = 0;
    endtask

    // A window is the 3x3 block of the current frame ending at the accepted pixel.
    task automatic model_accept(input logic sof, input int pix);
        int r, c;
        r = sof ? 0 : m_row;
        c = sof ? 0 : m_col;
        img[r][c] = pix;
        if (r >= 2 && c >= 2) begin
            exp_valid = 1'b1;
            exp_eof   = (r == H - 1) && (c == W - 1);
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    exp_win[3*i + j] = img[r - 2 + i][c - 2 + j];
        end
        c++;
        if (c == W) begin
            c = 0;
            r = (r == H - 1) ? 0 : r + 1;
        end
        m_row = r;
        m_col = c;
    endtask

    task automatic check_outputs();
        check_val("out_valid", int'(out_valid), int'(exp_valid));
        check_val("out_eof", int'(out_eof), int'(exp_valid && exp_eof));
        for (int k = 0; k < 9; k++)
            check_val($sformatf("in%0d", k + 1), int'(dut_win[k]), exp_win[k]);
        if (out_valid === 1'b1) dut_win_cnt++;
        if (out_eof === 1'b1) dut_eof_cnt++;
    endtask

    task automatic cycle(input logic v, input logic s, input int pix);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_pixel = DW'(pix);
        @(posedge clk);
        exp_valid = 1'b0;
        exp_eof   = 1'b0;
        if (v) model_accept(s, pix);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        exp_valid = 1'b0;
        exp_eof = 1'b0;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0: 10r+c+base, mode 1: random pixels; max_gap idle cycles after pixels
    task automatic send_frame(input int base, input int mode, input int max_gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                cycle(1'b1, (r == 0 && c == 0), (mode == 0) ? base + 10*r + c : int'($urandom_range(0, 255)));
                if (max_gap > 0) repeat ($urandom_range(0, max_gap)) cycle(1'b0, 1'b0, int'($urandom_range(0, 255)));
            end
    endtask

    initial begin
        do_reset();

        // continuous frame p = 10r+c: 4 windows, one eof
        dut_win_cnt = 0; dut_eof_cnt = 0;
        send_frame(0, 0, 0);
        check_val("frame_windows", dut_win_cnt, 4);
        check_val("frame_eofs", dut_eof_cnt, 1);

        // idle gaps: 1,0,0,1 pattern
        dut_win_cnt = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                cycle(1'b1, (r == 0 && c == 0), 10*r + c);
                cycle(1'b0, 1'b0, 8'hAA);
                cycle(1'b0, 1'b0, 8'h55);
            end
        check_val("gap_windows", dut_win_cnt, 4);

        // back-to-back frames, second offset by 100
        send_frame(0, 0, 0);
        send_frame(100, 0, 0);

        // sof abandons frame at (3,1)
        dut_eof_cnt = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r < 3 || c < 1) cycle(1'b1, (r == 0 && c == 0), 10*r + c);
        check_val("abandon_no_eof", dut_eof_cnt, 0);
        dut_win_cnt = 0;
        send_frame(50, 0, 0);
        check_val("after_sof_windows", dut_win_cnt, 4);
        check_val("after_sof_eof", dut_eof_cnt, 1);

        // reset mid-frame during row 2, then a fresh frame
        for (int i = 0; i < 2*W + 2; i++) cycle(1'b1, (i == 0), 200 + i);
        do_reset();
        for (int i = 0; i < W*H; i++) cycle(1'b1, 1'b0, 10*(i / W) + (i % W));

        // randomised frames with random gaps and occasional mid-frame sof
        for (int f = 0; f < 20; f++) begin
            send_frame(0, 1, (f % 3));
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < int'($urandom_range(1, 12)); i++)
                    cycle(1'b1, (i == 0), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) cycle(1'b0, 1'b1, 0);
        end
        for (int i = 0; i < 200; i++)
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0), int'($urandom_range(0, 255)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
